// File: rtl/counter.sv
// Free-running modulo-2^WIDTH up-counter that supplies the partial-product step index
// for the sequential multiplier; an asynchronous active-low clear returns it to step 0.
module counter #(
    parameter int WIDTH = 2
) (
    input  logic             clk,
    input  logic             aclr_n,
    output logic [WIDTH-1:0] count_out
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    // Natural overflow of the WIDTH-bit add gives the 2^WIDTH-1 -> 0 wrap with no flag.
    always_comb begin
        count_d = count_q + {{(WIDTH-1){1'b0}}, 1'b1};
    end

    always_ff @(posedge clk or negedge aclr_n) begin
        if (!aclr_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_out = count_q;

endmodule

// File: tb/tb_counter.sv
// Directed bench for counter: checks the WIDTH=2 instance through clear, count, wrap and
// mid-count clears, and the WIDTH=3 instance through a full wrap after release.
module tb_counter;

    logic       clk;
    logic       aclr_n;
    logic       aclr3_n;
    logic [1:0] cnt2;
    logic [2:0] cnt3;

    int vectors;
    int miscompares;

    counter #(.WIDTH(2)) dut2 (
        .clk       (clk),
        .aclr_n    (aclr_n),
        .count_out (cnt2)
    );

    counter #(.WIDTH(3)) dut3 (
        .clk       (clk),
        .aclr_n    (aclr3_n),
        .count_out (cnt3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Advance to the next rising edge and settle 1 unit past it.
    task automatic edge_sample();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [1:0] exp_run[6];
        logic [2:0] exp_w3[9];
        vectors     = 0;
        miscompares = 0;
        exp_run = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2};
        exp_w3  = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd0, 3'd1};

        // Power-up clear, asserted before the first edge at t=5.
        aclr_n  = 1'b1;
        aclr3_n = 1'b1;
        #1;
        aclr_n  = 1'b0;
        aclr3_n = 1'b0;
        #1;
        check("pwrup_pre_edge", {6'd0, cnt2}, 8'd0);
        check("pwrup_pre_edge_w3", {5'd0, cnt3}, 8'd0);
        for (int i = 0; i < 2; i++) begin
            edge_sample();
            check($sformatf("pwrup_hold%0d", i), {6'd0, cnt2}, 8'd0);
        end

        // Release between edges, then count and wrap.
        #3;
        aclr_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            edge_sample();
            check($sformatf("count%0d", i), {6'd0, cnt2}, {6'd0, exp_run[i]});
        end

        // Asynchronous clear at count 2, checked before the next edge.
        #3;
        aclr_n = 1'b0;
        #1;
        check("async_clr_mid", {6'd0, cnt2}, 8'd0);
        for (int i = 0; i < 3; i++) begin
            edge_sample();
            check($sformatf("hold_clr%0d", i), {6'd0, cnt2}, 8'd0);
        end
        #3;
        aclr_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            edge_sample();
            check($sformatf("after_hold%0d", i), {6'd0, cnt2}, {6'd0, exp_run[i]});
        end

        // Short 3-unit clear pulse at count 3.
        check("pre_pulse", {6'd0, cnt2}, 8'd3);
        #2;
        aclr_n = 1'b0;
        #1;
        check("pulse_clr", {6'd0, cnt2}, 8'd0);
        #2;
        aclr_n = 1'b1;
        edge_sample();
        check("pulse_next", {6'd0, cnt2}, 8'd1);

        // WIDTH=3 instance: held in clear until now, then a full wrap.
        check("w3_held", {5'd0, cnt3}, 8'd0);
        #3;
        aclr3_n = 1'b1;
        for (int i = 0; i < 9; i++) begin
            edge_sample();
            check($sformatf("w3_count%0d", i), {5'd0, cnt3}, {5'd0, exp_w3[i]});
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
